// File: rtl/arm_instr_fetch.sv
// Instruction supply for the ARM datapath: small instruction RAM, PC sequencer and a registered,
// stallable Instr stream. Optional issue counter enabled by defining INSTR_CNT_EN.
module arm_instr_fetch #(
  parameter int unsigned AW       = 8,
  parameter int unsigned PROG_LEN = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          start,
  input  logic          stall,
  output logic [31:0]   Instr,
  output logic          instr_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
`ifdef INSTR_CNT_EN
  ,
  output logic [15:0]   issue_cnt
`endif
);

  localparam int unsigned Depth  = 2 ** AW;
  localparam int unsigned LastPc = (PROG_LEN == 0) ? 0 : PROG_LEN - 1;

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDone} state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem [Depth];
  logic [31:0]   instr_d;
  logic          valid_d;
  logic [AW-1:0] pc_d;
  logic          busy_d;
  logic          done_d;
  logic          load_ok;
  logic          mem_we;
  logic          last;
  logic [AW-1:0] pc_next;
  logic [31:0]   first_word;

  assign load_ok = (state_q == StIdle) || (state_q == StDone);
  assign mem_we  = wr_en && load_ok;
  assign last    = (32'(pc) == LastPc);
  assign pc_next = pc + AW'(1);
  // A write to word 0 in the start cycle lands this edge, so forward it to the first fetch.
  assign first_word = (mem_we && (wr_addr == '0)) ? wr_data : mem[0];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef INSTR_CNT_EN
  logic [15:0] cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    instr_d = Instr;
    valid_d = instr_valid;
    pc_d    = pc;
    busy_d  = busy;
    done_d  = done;
`ifdef INSTR_CNT_EN
    cnt_d   = issue_cnt;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
`ifdef INSTR_CNT_EN
          cnt_d = '0;
`endif
          pc_d = '0;
          if (PROG_LEN != 0) begin
            state_d = StFetch;
            instr_d = first_word;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end else begin
            state_d = StDone;
            instr_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      StFetch, StHold: begin
        if (stall) begin
          state_d = StHold;
        end else begin
`ifdef INSTR_CNT_EN
          if (issue_cnt != 16'hFFFF) cnt_d = issue_cnt + 16'd1;
`endif
          if (last) begin
            state_d = StDone;
            instr_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StFetch;
            pc_d    = pc_next;
            instr_d = mem[pc_next];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      Instr       <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      Instr       <= instr_d;
      instr_valid <= valid_d;
      pc          <= pc_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

`ifdef INSTR_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt <= '0;
    end else begin
      issue_cnt <= cnt_d;
    end
  end
`endif

endmodule

// File: doc/arm_instr_fetch.md
Name: arm_instr_fetch

Overview:
- Instruction-supply side of the ARM data-processing datapath: holds a small instruction RAM, sequences a PC, and drives Instr into the datapath one instruction per clock.
- Replaces ad-hoc negedge instruction driving with a registered, stallable stream plus a write port for program loading.
- Sits between the program loader (bench or boot logic) and the datapath's Instr input.

Parameters:
- AW, 8, instruction RAM address width; depth = 2**AW words of 32 bits.
- PROG_LEN, 7, number of instructions issued per run; legal range 0..2**AW.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  program-load write strobe.
- wr_addr  in  AW  program-load word address.
- wr_data  in  32  program-load instruction word.
- start  in  1  single-cycle pulse that begins a run from address 0.
- stall  in  1  datapath not consuming; hold the current instruction.
- Instr  out  32  instruction to the datapath.
- instr_valid  out  1  Instr is a live instruction.
- pc  out  AW  RAM address of the instruction currently on Instr.
- busy  out  1  run in progress (FETCH or HOLD).
- done  out  1  run completed; stays high until the next start.

Behaviour:
- Reset (reset_n low, async): state IDLE; Instr=0, instr_valid=0, pc=0, busy=0, done=0. RAM contents are not reset.
- FSM states are IDLE, FETCH, HOLD and DONE. All outputs are registered.
- IDLE/DONE:
  - wr_en writes wr_data to mem[wr_addr] at the clock edge.
  - start with PROG_LEN>0 → FETCH. Next edge: pc=0, Instr=mem[0], instr_valid=1, busy=1, done=0.
  - start with PROG_LEN=0 → DONE directly (done=1 next cycle, instr_valid never asserted).
- FETCH, stall=0: instruction at pc is consumed this edge.
  - If pc < PROG_LEN-1: pc advances by 1 and Instr=mem[pc+1] on the next cycle.
  - If pc = PROG_LEN-1: go to DONE. Next cycle: instr_valid=0, Instr=0, busy=0, done=1, pc holds the last address.
- FETCH, stall=1 → HOLD. Instr, pc and instr_valid are frozen.
- HOLD: stays in HOLD while stall=1. stall=0 consumes the held instruction; advance/finish exactly as in FETCH.
- Latency: start to first valid Instr is 1 cycle. With no stalls, one instruction per cycle; a run takes PROG_LEN cycles of instr_valid.
- Whenever instr_valid=0, Instr is forced to 32'h0.
- wr_en while busy is ignored (no RAM write). A write to the address about to be fetched must not corrupt the run.
- start while busy is ignored. start in DONE restarts from pc=0.
- start and wr_en in the same IDLE cycle: the write completes first, then the run reads the new contents.
- pc never wraps: PROG_LEN=2**AW ends at pc=2**AW-1 → DONE.
- reset_n asserted mid-run: immediate return to reset values; the run is abandoned.

Optional Feature:
- Macro INSTR_CNT_EN.
- Defined: adds output issue_cnt [15:0], the count of instructions consumed (issued with stall=0).
  - Cleared to 0 by reset and by an accepted start.
  - Saturates at 16'hFFFF.
  - Increments on the same edge the instruction is consumed.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Load mem[0..6] = E2800005, E2811003, E0802001, E0423000, E1A04002, E3A0500A, E0856004; pulse start → Instr shows these 7 words on 7 consecutive cycles with pc 0..6. Then done=1, instr_valid=0, Instr=0 (issue_cnt=7 if enabled).
- Same program, hold stall=1 for 3 cycles while pc=2 → Instr stays E0802001 for 4 cycles total. Run finishes 3 cycles later than the no-stall run; no instruction skipped or duplicated.
- Pulse start at pc=3 mid-run, and wr_en to addr 4 with wr_data=FFFFFFFF → both ignored; sequence unchanged, mem[4] still E1A04002 on the next run.
- Drop reset_n while pc=4 → outputs zero asynchronously. After release and start, the run restarts at mem[0]=E2800005 (RAM preserved).
- Build with PROG_LEN=0; pulse start → done=1 next cycle, instr_valid never high.
- After done=1, write mem[0]=E3A00001 and pulse start in the same cycle → first issued Instr is E3A00001.
